// File: rtl/axis_dram_fifo_dual_if.sv
// Two-lane AXI-Stream bundle for axis_dram_fifo_dual.
// Lane n occupies bits [64n+63:64n] of the data buses and bit n of the flags.
// The slave modport is the FIFO side; the master modport is the traffic side.
interface axis_dram_fifo_dual_if;
  logic [127:0] i_tdata;
  logic [1:0]   i_tlast;
  logic [1:0]   i_tvalid;
  logic [1:0]   i_tready;
  logic [127:0] o_tdata;
  logic [1:0]   o_tlast;
  logic [1:0]   o_tvalid;
  logic [1:0]   o_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/axis_dram_fifo_dual.sv
// Dual independent AXI-Stream FIFOs, one per 64-bit lane.
// Each entry holds {tlast, tdata}. The head word is presented first-word
// fall-through and appears one cycle after it is written.
// init_calib_complete either rises right after reset (on-chip RAM) or after
// CALIB_CYCLES cycles (calibrated-memory timing model).
// Optional macro AXIS_DRAM_FIFO_DUAL_OCC_EN adds the per-lane 'occupied' word count.
module axis_dram_fifo_dual #(
  parameter int USE_SRAM_MEMORY = 1,
  parameter int DEPTH_LOG2      = 9,
  parameter int CALIB_CYCLES    = 1000
) (
  input  logic                          bus_clk,
  input  logic                          bus_rst,
  axis_dram_fifo_dual_if.slave          axis,
`ifdef AXIS_DRAM_FIFO_DUAL_OCC_EN
  output logic [2*(DEPTH_LOG2+1)-1:0]   occupied,
`endif
  output logic                          init_calib_complete
);

  localparam int DATA_W   = 64;
  localparam int PTR_W    = DEPTH_LOG2 + 1;
  localparam int CAL_W    = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam int CAL_LAST = ((USE_SRAM_MEMORY != 0) || (CALIB_CYCLES <= 1)) ? 0 : CALIB_CYCLES - 1;

  logic             calib_done;
  logic [CAL_W-1:0] cal_cnt;

  logic [1:0]          rdy_c;
  logic [1:0]          vld_c;
  logic [1:0]          last_c;
  logic [2*DATA_W-1:0] data_c;

  // Calibration: count cycles since reset release, then latch done until the next reset
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      calib_done <= 1'b0;
      cal_cnt    <= '0;
    end else if (!calib_done) begin
      if (cal_cnt == CAL_W'(CAL_LAST)) begin
        calib_done <= 1'b1;
      end else begin
        cal_cnt <= cal_cnt + CAL_W'(1);
      end
    end
  end

  assign init_calib_complete = calib_done;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [DATA_W:0]  mem [2**DEPTH_LOG2];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign rdy_c[ch] = calib_done & ~full;
    assign vld_c[ch] = calib_done & ~empty;
    assign push      = axis.i_tvalid[ch] & rdy_c[ch];
    assign pop       = vld_c[ch] & axis.o_tready[ch];

    // Head word read combinationally; forced to zero whenever no word is offered
    assign {last_c[ch], data_c[ch*DATA_W +: DATA_W]} =
      vld_c[ch] ? mem[rd_ptr[PTR_W-2:0]] : '0;

    // Storage write; contents are not reset, the pointers define validity
    always_ff @(posedge bus_clk) begin
      if (push) begin
        mem[wr_ptr[PTR_W-2:0]] <= {axis.i_tlast[ch], axis.i_tdata[ch*DATA_W +: DATA_W]};
      end
    end

    // Pointer update; reset discards every stored word, including partial packets
    always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end

`ifdef AXIS_DRAM_FIFO_DUAL_OCC_EN
    assign occupied[ch*PTR_W +: PTR_W] = wr_ptr - rd_ptr;
`endif
  end

  assign axis.i_tready = rdy_c;
  assign axis.o_tvalid = vld_c;
  assign axis.o_tlast  = last_c;
  assign axis.o_tdata  = data_c;

endmodule

// File: tb/tb_axis_dram_fifo_dual.sv
// Self-checking bench for axis_dram_fifo_dual: randomized traffic against a
// queue-based reference model, plus a second instance using the calibrated
// memory timing model.
module tb_axis_dram_fifo_dual;

  localparam int DEPTH_LOG2 = 9;
  localparam int DEPTH      = 2**DEPTH_LOG2;
  localparam int CAL2       = 20;
  localparam int OW         = DEPTH_LOG2 + 1;

  logic bus_clk = 1'b0;
  logic bus_rst;
  logic init_a;
  logic init_b;

  always #5 bus_clk = ~bus_clk;

  axis_dram_fifo_dual_if axis_a ();
  axis_dram_fifo_dual_if axis_b ();

`ifdef AXIS_DRAM_FIFO_DUAL_OCC_EN
  logic [2*OW-1:0] occ_a;
  logic [2*OW-1:0] occ_b;
`endif

  axis_dram_fifo_dual #(
    .USE_SRAM_MEMORY(1), .DEPTH_LOG2(DEPTH_LOG2), .CALIB_CYCLES(1000)
  ) dut_a (
    .bus_clk(bus_clk),
    .bus_rst(bus_rst),
    .axis(axis_a),
`ifdef AXIS_DRAM_FIFO_DUAL_OCC_EN
    .occupied(occ_a),
`endif
    .init_calib_complete(init_a)
  );

  axis_dram_fifo_dual #(
    .USE_SRAM_MEMORY(0), .DEPTH_LOG2(4), .CALIB_CYCLES(CAL2)
  ) dut_b (
    .bus_clk(bus_clk),
    .bus_rst(bus_rst),
    .axis(axis_b),
`ifdef AXIS_DRAM_FIFO_DUAL_OCC_EN
    .occupied(occ_b[9:0]),
`endif
    .init_calib_complete(init_b)
  );

`ifdef AXIS_DRAM_FIFO_DUAL_OCC_EN
  assign occ_b[2*OW-1:10] = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [64:0] q0[$];
  logic [64:0] q1[$];
  int          rel_edges;
  bit          in_rst;
  int          i_mode[2];
  int          o_mode[2];
  bit          pkt_mode[2];
  int          send_left[2];
  int          seq[2];
  logic [64:0] cur_word[2];
  int          out_seen[2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int qsize(input int ch);
    return (ch == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [64:0] qhead(input int ch);
    return (ch == 0) ? q0[0] : q1[0];
  endfunction

  function automatic logic [64:0] gen_word(input int ch);
    logic [64:0] w;
    if (pkt_mode[ch]) begin
      w = {(seq[ch] % 64) == 63, 64'(seq[ch] % 64)};
      seq[ch]++;
    end else begin
      w = {1'($urandom_range(0, 1)), $urandom, $urandom};
    end
    return w;
  endfunction

  function automatic bit pick(input int mode, input int pct);
    return (mode == 1) || ((mode == 2) && ($urandom_range(0, 99) < pct));
  endfunction

  // One bus cycle: check outputs against the model, drive new inputs, advance the model
  task automatic step(input bit rst_v);
    bit          cal_a, cal_b;
    bit          ev[2];
    bit          er[2];
    bit          v, r;
    bit          do_push[2];
    bit          do_pop[2];
    logic [64:0] hd;
    @(negedge bus_clk);
    cal_a = (rel_edges >= 1);
    cal_b = (rel_edges >= CAL2);
    chk("init_calib_complete", init_a, cal_a);
    chk("calib model init", init_b, cal_b);
    chk("calib model o_tvalid", axis_b.o_tvalid, 2'b00);
    for (int ch = 0; ch < 2; ch++) begin
      ev[ch] = cal_a && (qsize(ch) > 0);
      er[ch] = cal_a && (qsize(ch) < DEPTH);
      chk($sformatf("i_tready[%0d]", ch), axis_a.i_tready[ch], er[ch]);
      chk($sformatf("o_tvalid[%0d]", ch), axis_a.o_tvalid[ch], ev[ch]);
      if (ev[ch]) begin
        hd = qhead(ch);
        chk($sformatf("o_tdata[%0d]", ch), axis_a.o_tdata[ch*64 +: 64], hd[63:0]);
        chk($sformatf("o_tlast[%0d]", ch), axis_a.o_tlast[ch], hd[64]);
      end
      if (in_rst) begin
        chk($sformatf("reset o_tdata[%0d]", ch), axis_a.o_tdata[ch*64 +: 64], 0);
        chk($sformatf("reset o_tlast[%0d]", ch), axis_a.o_tlast[ch], 0);
      end
`ifdef AXIS_DRAM_FIFO_DUAL_OCC_EN
      chk($sformatf("occupied[%0d]", ch), occ_a[ch*OW +: OW], qsize(ch));
`endif
    end

    bus_rst = rst_v;
    for (int ch = 0; ch < 2; ch++) begin
      v = (send_left[ch] > 0) && pick(i_mode[ch], 70);
      r = pick(o_mode[ch], 50);
      axis_a.i_tvalid[ch]          = v;
      axis_a.i_tdata[ch*64 +: 64]  = cur_word[ch][63:0];
      axis_a.i_tlast[ch]           = cur_word[ch][64];
      axis_a.o_tready[ch]          = r;
      if (r && axis_a.o_tvalid[ch] && !rst_v) out_seen[ch]++;
      do_push[ch] = v && er[ch];
      do_pop[ch]  = r && ev[ch];
    end

    if (rst_v) begin
      q0.delete();
      q1.delete();
      rel_edges = 0;
      in_rst    = 1'b1;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (do_pop[ch]) begin
          if (ch == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (do_push[ch]) begin
          if (ch == 0) q0.push_back(cur_word[ch]); else q1.push_back(cur_word[ch]);
          send_left[ch]--;
          cur_word[ch] = gen_word(ch);
        end
      end
      if (rel_edges < 1000000) rel_edges++;
      in_rst = 1'b0;
    end
    @(posedge bus_clk);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (((send_left[0] > 0) || (send_left[1] > 0) || (q0.size() > 0) || (q1.size() > 0))
           && (k < budget)) begin
      step(1'b0);
      k++;
    end
    #1;
    chk("drained o_tvalid", axis_a.o_tvalid, 2'b00);
  endtask

  task automatic setup(input int ch, input bit pm, input int im, input int om, input int n);
    pkt_mode[ch]  = pm;
    seq[ch]       = 0;
    i_mode[ch]    = im;
    o_mode[ch]    = om;
    send_left[ch] = n;
    out_seen[ch]  = 0;
    cur_word[ch]  = gen_word(ch);
  endtask

  initial begin
    bus_rst         = 1'b1;
    axis_a.i_tdata  = '0;
    axis_a.i_tlast  = '0;
    axis_a.i_tvalid = '0;
    axis_a.o_tready = '0;
    axis_b.i_tdata  = '0;
    axis_b.i_tlast  = '0;
    axis_b.i_tvalid = '0;
    axis_b.o_tready = '0;
    for (int ch = 0; ch < 2; ch++) setup(ch, 1'b0, 0, 0, 0);
    @(posedge bus_clk);
    in_rst    = 1'b1;
    rel_edges = 0;
    repeat (3) step(1'b1);
    #1;
    chk("calib low in reset", init_a, 1'b0);

    // Reset release: calibration completes one cycle later on the on-chip RAM build
    step(1'b0);
    #1;
    chk("calib one cycle after release", init_a, 1'b1);
    repeat (CAL2 + 2) step(1'b0);

    // Channel 0 only, 10 packets of 0..63
    setup(0, 1'b1, 1, 1, 640);
    setup(1, 1'b0, 0, 0, 0);
    drain(3000);
    chk("ch0 words out", out_seen[0], 640);
    chk("ch1 idle words", out_seen[1], 0);

    // Channel 1 only, same packets
    setup(0, 1'b0, 0, 0, 0);
    setup(1, 1'b1, 1, 1, 640);
    drain(3000);
    chk("ch1 words out", out_seen[1], 640);
    chk("ch0 idle words", out_seen[0], 0);

    // Both lanes concurrently, random data and random handshakes
    setup(0, 1'b0, 2, 2, 640);
    setup(1, 1'b0, 2, 2, 640);
    drain(20000);
    chk("ch0 random words", out_seen[0], 640);
    chk("ch1 random words", out_seen[1], 640);

    // Fill channel 0 to capacity with the output stalled
    setup(0, 1'b0, 1, 0, DEPTH + 1);
    setup(1, 1'b0, 2, 1, 100);
    repeat (DEPTH + 8) step(1'b0);
    #1;
    chk("full i_tready", axis_a.i_tready[0], 1'b0);
    chk("full o_tvalid", axis_a.o_tvalid[0], 1'b1);
`ifdef AXIS_DRAM_FIFO_DUAL_OCC_EN
    chk("full occupied", occ_a[0 +: OW], DEPTH);
`endif
    o_mode[0] = 1;
    step(1'b0);
    o_mode[0] = 0;
    #1;
    chk("ready after pop", axis_a.i_tready[0], 1'b1);
    o_mode[0] = 1;
    drain(3000);

    // Reset with words in flight: nothing may come out afterwards
    setup(0, 1'b0, 1, 0, 20);
    setup(1, 1'b0, 1, 0, 7);
    repeat (25) step(1'b0);
    #1;
    chk("pre-reset o_tvalid", axis_a.o_tvalid, 2'b11);
    step(1'b1);
    step(1'b1);
    o_mode[0] = 1;
    o_mode[1] = 1;
    repeat (10) step(1'b0);
    #1;
    chk("post-reset o_tvalid", axis_a.o_tvalid, 2'b00);
`ifdef AXIS_DRAM_FIFO_DUAL_OCC_EN
    chk("post-reset occupied", occ_a, 0);
`endif
    repeat (CAL2 + 2) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
